// File: rtl/rsa_param_gen_if.sv
// Handshake bundle for the RSA parameter generator: run request
// (start/seed/offset), result fields and the valid/ready pair.
//   master : request driver / result consumer
//   slave  : the generator
interface rsa_param_gen_if #(
    parameter int W = 4
);
    logic           start;
    logic [W-1:0]   seed;
    logic [7:0]     offset;
    logic           out_ready;
    logic           busy;
    logic           out_valid;
    logic [W-1:0]   p_out;
    logic [W-1:0]   q_out;
    logic [2*W-1:0] n;
    logic [2*W-1:0] lamda;

    modport master (
        output start, seed, offset, out_ready,
        input  busy, out_valid, p_out, q_out, n, lamda
    );

    modport slave (
        input  start, seed, offset, out_ready,
        output busy, out_valid, p_out, q_out, n, lamda
    );
endinterface

// File: rtl/rsa_param_gen.sv
// Toy RSA parameter generator: picks p and q from a Fibonacci-style
// LFSR, then registers n = p*q and lamda = (p-1)*(q-1).
// Ports: clk, reset (sync, active-high), bus (slave modport):
//   start/seed/offset in, out_ready in, busy/out_valid/p_out/q_out/n/lamda out.
module rsa_param_gen #(
    parameter int           W    = 4,
    parameter logic [W-1:0] TAPS = 4'b0011,
    parameter int           GAP  = 5
) (
    input logic           clk,
    input logic           reset,
    rsa_param_gen_if.slave bus
);

    localparam logic [7:0]     GAP_C = 8'(GAP);
    localparam logic [W-1:0]   ONE_W = W'(1);
    localparam logic [W-1:0]   TWO_W = W'(2);
    localparam logic [2*W-1:0] ONE_2W = (2*W)'(1);

    typedef enum logic [2:0] {
        IDLE,
        RUN_P,
        RUN_Q,
        CALC,
        HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   lfsr_q, lfsr_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     off_q, off_d;
    logic [W-1:0]   p_q, p_d;
    logic [W-1:0]   q_q, q_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   pout_q, pout_d;
    logic [W-1:0]   qout_q, qout_d;
    logic [2*W-1:0] n_q, n_d;
    logic [2*W-1:0] lam_q, lam_d;

    logic [W-1:0]   lfsr_nxt;
    logic [7:0]     cnt_inc;
    logic [2*W-1:0] p_ext;
    logic [2*W-1:0] q_ext;

    assign lfsr_nxt = {^(lfsr_q & TAPS), lfsr_q[W-1:1]};
    // Counter saturates so a huge offset plus rejections never wraps.
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign p_ext    = {{W{1'b0}}, p_q};
    assign q_ext    = {{W{1'b0}}, q_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= ONE_W;
            cnt_q   <= '0;
            off_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            pout_q  <= '0;
            qout_q  <= '0;
            n_q     <= '0;
            lam_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            p_q     <= p_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            pout_q  <= pout_d;
            qout_q  <= qout_d;
            n_q     <= n_d;
            lam_q   <= lam_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        p_d     = p_q;
        q_d     = q_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        pout_d  = pout_q;
        qout_d  = qout_q;
        n_d     = n_q;
        lam_d   = lam_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // An all-zero LFSR would lock up; substitute 1.
                    lfsr_d  = (bus.seed == '0) ? ONE_W : bus.seed;
                    off_d   = bus.offset;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN_P;
                end
            end
            RUN_P: begin
                lfsr_d = lfsr_nxt;
                if (cnt_q >= off_q && lfsr_q >= TWO_W) begin
                    p_d     = lfsr_q;
                    cnt_d   = '0;
                    state_d = RUN_Q;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN_Q: begin
                lfsr_d = lfsr_nxt;
                // q must differ from p, otherwise n is a square.
                if (cnt_q >= GAP_C && lfsr_q >= TWO_W &&
                    lfsr_q != p_q) begin
                    q_d     = lfsr_q;
                    state_d = CALC;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            CALC: begin
                // Both factors are >= 2, so the decrements cannot underflow.
                n_d     = p_ext * q_ext;
                lam_d   = (p_ext - ONE_2W) * (q_ext - ONE_2W);
                pout_d  = p_q;
                qout_d  = q_q;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (valid_q && bus.out_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.p_out     = pout_q;
    assign bus.q_out     = qout_q;
    assign bus.n         = n_q;
    assign bus.lamda     = lam_q;

endmodule

// File: tb/tb_rsa_param_gen.sv
// Directed bench for rsa_param_gen with W=4, TAPS=0011, GAP=5.
// LFSR order from 8: 8,4,2,9,12,6,11,5,10,13,14,15,7,3,1.
module tb_rsa_param_gen;

    logic clk = 1'b0;
    logic reset;
    int   vecs = 0;
    int   errs = 0;
    int   lat;
    int   seen;

    always #5 clk = ~clk;

    rsa_param_gen_if #(.W(4)) bus ();

    rsa_param_gen #(
        .W   (4),
        .TAPS(4'b0011),
        .GAP (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start sampled in cycle T; after the first tick we are in T+1.
    task automatic wait_valid(output int l);
        l = 1;
        while (bus.out_valid !== 1'b1 && l < 60) begin
            tick();
            l++;
        end
    endtask

    task automatic do_run(input string tag, input logic [3:0] sd,
                          input logic [7:0] off, input int exp_lat,
                          input int ep, input int eq, input int en,
                          input int el);
        int l;
        bus.start     = 1'b1;
        bus.seed      = sd;
        bus.offset    = off;
        bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        wait_valid(l);
        chk({tag, "_lat"}, l, exp_lat);
        chk({tag, "_p"}, 32'(bus.p_out), ep);
        chk({tag, "_q"}, 32'(bus.q_out), eq);
        chk({tag, "_n"}, 32'(bus.n), en);
        chk({tag, "_lam"}, 32'(bus.lamda), el);
        tick();
        chk({tag, "_done_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_keep_n"}, 32'(bus.n), en);
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.seed      = '0;
        bus.offset    = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_p", 32'(bus.p_out), 0);
        chk("rst_q", 32'(bus.q_out), 0);
        chk("rst_n", 32'(bus.n), 0);
        chk("rst_lam", 32'(bus.lamda), 0);
        reset = 1'b0;
        tick();

        do_run("s8", 4'd8, 8'd0, 9, 8, 11, 88, 70);
        do_run("s3", 4'd3, 8'd1, 11, 8, 11, 88, 70);
        do_run("s10", 4'd10, 8'd0, 10, 10, 8, 80, 63);
        do_run("s0", 4'd0, 8'd0, 10, 8, 11, 88, 70);

        // Back-pressure with start pulses that must be ignored.
        bus.start     = 1'b1;
        bus.seed      = 4'd8;
        bus.offset    = 8'd0;
        bus.out_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        wait_valid(lat);
        chk("hold_lat", lat, 9);
        for (int i = 0; i < 20; i++) begin
            bus.start  = i[0];
            bus.seed   = 4'(i);
            bus.offset = 8'd0;
            tick();
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_busy", 32'(bus.busy), 1);
            chk("hold_n", 32'(bus.n), 88);
            chk("hold_lam", 32'(bus.lamda), 70);
            chk("hold_q", 32'(bus.q_out), 11);
        end
        // Start on the handshake cycle is also ignored.
        bus.start     = 1'b1;
        bus.seed      = 4'd10;
        bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("hs_valid", 32'(bus.out_valid), 0);
        chk("hs_busy", 32'(bus.busy), 0);
        chk("hs_keep_n", 32'(bus.n), 88);
        tick();
        chk("hs_no_restart", 32'(bus.busy), 0);

        // Reset in RUN_Q aborts the run.
        bus.start  = 1'b1;
        bus.seed   = 4'd8;
        bus.offset = 8'd0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_valid", 32'(bus.out_valid), 0);
        chk("abort_n", 32'(bus.n), 0);
        chk("abort_lam", 32'(bus.lamda), 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        chk("abort_no_result", seen, 0);
        do_run("after", 4'd10, 8'd0, 10, 10, 8, 80, 63);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/rsa_param_gen.md
RSA_PARAM_GEN -- requirements
Module: rsa_param_gen

Interface
REQ-001 SHALL have parameter W, default 4, LFSR and sampled-value width.
REQ-002 SHALL have parameter TAPS, default 4'b0011, W-bit feedback tap mask.
REQ-003 SHALL have parameter GAP, default 5, minimum LFSR steps between p capture and q capture (1..255).
REQ-004 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a generation run; honoured only in IDLE.
REQ-007 SHALL have port seed  in  W  LFSR seed, sampled on the accepted start cycle.
REQ-008 SHALL have port offset  in  8  LFSR steps before p becomes eligible, sampled on the accepted start cycle.
REQ-009 SHALL have port out_ready  in  1  consumer accepts the result.
REQ-010 SHALL have port busy  out  1  high from the cycle after an accepted start until the result handshake.
REQ-011 SHALL have port out_valid  out  1  result fields are valid.
REQ-012 SHALL have port p_out, q_out  out  W  captured factors.
REQ-013 SHALL have port n  out  2W  p*q.
REQ-014 SHALL have port lamda  out  2W  (p-1)*(q-1).

Function
REQ-015 SHALL step the LFSR as lfsr <= {fb, lfsr[W-1:1]}, with fb = XOR-reduce(lfsr & TAPS).
REQ-016 SHALL step the LFSR every cycle in RUN_P and RUN_Q, and SHALL hold it in all other states.
REQ-017 SHALL implement FSM states IDLE, RUN_P, RUN_Q, CALC and HOLD.
REQ-018 SHALL, in IDLE with start=1, load lfsr<=seed (or 1 when seed==0), store offset, clear cnt, set busy=1, and go to RUN_P.
REQ-019 SHALL, in RUN_P, capture p<=lfsr when cnt>=offset and lfsr>=2, then clear cnt and go to RUN_Q; otherwise cnt SHALL increment.
REQ-020 SHALL, in RUN_Q, capture q<=lfsr when cnt>=GAP, lfsr>=2 and lfsr!=p, then go to CALC; otherwise cnt SHALL increment.
REQ-021 SHALL saturate cnt at 8 bits, never wrap, and keep retrying a rejected value on each subsequent cycle.
REQ-022 SHALL, in CALC, register n<=p*q and lamda<=(p-1)*(q-1) at full 2W width with no truncation, update p_out/q_out, set out_valid=1, and go to HOLD.
REQ-023 SHALL, in HOLD, hold out_valid and all result fields stable until out_ready=1.
REQ-024 SHALL, on the out_valid&&out_ready cycle, clear out_valid and busy on the next edge and go to IDLE.
REQ-025 SHALL retain result fields after the handshake until the next CALC.
REQ-026 SHALL ignore start when the FSM is not in IDLE, including on the handshake cycle itself.
REQ-027 SHALL, with no rejections, assert out_valid exactly offset+GAP+4 cycles after the start cycle; each rejected sample SHALL add one cycle.
REQ-028 SHALL drive out_valid, n and lamda only from registers, with no combinational path from inputs.

Reset
REQ-029 SHALL, while reset=1, force FSM=IDLE, lfsr=1, cnt=0, busy=0, out_valid=0, p_out=0, q_out=0, n=0 and lamda=0.
REQ-030 SHALL give reset priority over start and out_ready in the same cycle.
REQ-031 SHALL abort an in-progress run on reset, with no result produced.

Verification (W=4, TAPS=0011, GAP=5; LFSR sequence from 8: 8,4,2,9,12,6,11,5,10,13,14,15,7,3,1)
REQ-032 SHALL cover: seed=8, offset=0, start at T, out_ready=1 -> out_valid at T+9, p=8, q=11, n=88, lamda=70, busy low at T+10.
REQ-033 SHALL cover: seed=3, offset=1 -> value 1 rejected at cnt=1, p=8, q=11, n=88, lamda=70, out_valid at T+11 (one cycle late).
REQ-034 SHALL cover: seed=10, offset=0 -> q candidate 1 rejected, q=8, n=80, lamda=63, out_valid at T+10.
REQ-035 SHALL cover: seed=0, offset=0 -> loads 1, 1 rejected, p=8, q=11, n=88, lamda=70, out_valid at T+10.
REQ-036 SHALL cover: out_ready=0 for 20 cycles while start pulses -> out_valid and fields stable, no restart; handshake then IDLE.
REQ-037 SHALL cover: reset asserted in RUN_Q -> next cycle busy=0, out_valid=0, n=0, lamda=0; a new start then runs normally.
